// File: rtl/display_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scan controller.
// Each digit gets a dark guard interval (BLANK) followed by its lit window
// (SHOW). Display content comes from a snapshot that is only replaced at the
// frame boundary, so a frame never mixes old and new digits.
module display_scan_ctrl #(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] digits,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  blink_mask,
    input  logic        upd_valid,
    output logic        upd_ready,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        frame_done
);

    // Counter widths: BLANK_CYCLES < PRESCALE, so one counter covers both states.
    localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int FR_W  = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [FR_W-1:0]  FRAME_LAST = FR_W'(BLINK_FRAMES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t            r_state;
    logic [2:0]        r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [FR_W-1:0]   r_frame_cnt;
    logic              r_blink_phase;

    logic [31:0]       r_digits;
    logic [7:0]        r_en;
    logic [7:0]        r_mask;

    logic [6:0]        r_seg;
    logic [7:0]        r_an;
    logic              r_frame_done;
    logic              r_upd_ready;

    state_t            w_state_nxt;
    logic [2:0]        w_idx_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_boundary;
    logic              w_next_boundary;
    logic [3:0]        w_nib;
    logic              w_dark;

    // Active-low segment pattern (g..a) for a hex nibble; 10-15 render blank.
    function automatic logic [6:0] seg_encode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign w_boundary      = (r_state == ST_SHOW) && (r_idx == 3'd7) && (r_cnt == SHOW_LAST);
    assign w_next_boundary = (w_state_nxt == ST_SHOW) && (w_idx_nxt == 3'd7) && (w_cnt_nxt == SHOW_LAST);
    assign w_nib           = r_digits[{r_idx, 2'b00} +: 4];
    assign w_dark          = !r_en[r_idx] || (r_mask[r_idx] && r_blink_phase);

    // Next scan position: count within a state, step digit index when SHOW ends.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (r_state == ST_BLANK) begin
            if (r_cnt == BLANK_LAST) begin
                w_state_nxt = ST_SHOW;
                w_cnt_nxt   = '0;
            end
        end else if (r_cnt == SHOW_LAST) begin
            w_state_nxt = ST_BLANK;
            w_idx_nxt   = r_idx + 3'd1;
            w_cnt_nxt   = '0;
        end
    end

    // Scan FSM with registered outputs, snapshot capture and blink timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_BLANK;
            r_idx         <= 3'd0;
            r_cnt         <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_digits      <= 32'h0;
            r_en          <= 8'h00;
            r_mask        <= 8'h00;
            r_seg         <= 7'h7F;
            r_an          <= 8'hFF;
            r_frame_done  <= 1'b0;
            r_upd_ready   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;

            // Handshake strobes are high only during the boundary cycle itself.
            r_frame_done <= w_next_boundary;
            r_upd_ready  <= w_next_boundary;

            // Outputs only move on state transitions; the SHOW window is steady.
            if (r_state == ST_BLANK && r_cnt == BLANK_LAST) begin
                if (w_dark) begin
                    r_an  <= 8'hFF;
                    r_seg <= 7'h7F;
                end else begin
                    r_an  <= ~(8'b1 << r_idx);
                    r_seg <= seg_encode(w_nib);
                end
            end else if (r_state == ST_SHOW && r_cnt == SHOW_LAST) begin
                r_an  <= 8'hFF;
                r_seg <= 7'h7F;
            end

            if (w_boundary) begin
                if (upd_valid && r_upd_ready) begin
                    r_digits <= digits;
                    r_en     <= digit_en;
                    r_mask   <= blink_mask;
                end
                if (r_frame_cnt == FRAME_LAST) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;
    assign upd_ready  = r_upd_ready;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with small timing parameters.
// Per-frame expected digit windows are queued at frame start and popped as
// each SHOW window opens.
module tb_display_scan_ctrl;

    localparam int P  = 10;
    localparam int B  = 2;
    localparam int BF = 2;
    localparam int W  = P + B;
    localparam int FR = 8 * W;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] digits;
    logic [7:0]  digit_en;
    logic [7:0]  blink_mask;
    logic        upd_valid;
    logic        upd_ready;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    exp_t        sb[$];
    logic [31:0] m_dig;
    logic [7:0]  m_en;
    logic [7:0]  m_mask;
    int          m_frame;
    logic [31:0] n_dig;
    logic [7:0]  n_en;
    logic [7:0]  n_mask;

    display_scan_ctrl #(
        .PRESCALE     (P),
        .BLANK_CYCLES (B),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_an"},  16'(an), 16'h00FF);
        chk({tag, "_seg"}, 16'(seg), 16'h007F);
        chk({tag, "_fd_rdy"}, 16'({frame_done, upd_ready}), 16'h0000);
    endtask

    // Check one frame cycle by cycle starting at its first BLANK cycle.
    // New inputs are applied at cycle 10, upd_valid raised at valid_at.
    task automatic run_frame(input int valid_at, input int stop_at);
        logic phase;
        logic acc;
        logic blank;
        exp_t cur;
        exp_t e;
        int   pos;
        phase = ((m_frame / BF) % 2) == 1;
        acc   = 1'b0;
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            blank = !m_en[i] || (m_mask[i] && phase);
            if (blank) e = '{an: 8'hFF, seg: 7'h7F};
            else       e = '{an: ~(8'b1 << i), seg: seg_of(m_dig[4*i +: 4])};
            sb.push_back(e);
        end
        cur = '{an: 8'hFF, seg: 7'h7F};
        for (int c = 0; c < FR; c++) begin
            if (c >= stop_at) break;
            pos = c % W;
            if (pos == B) cur = sb.pop_front();
            if (c == 10) begin
                digits     = n_dig;
                digit_en   = n_en;
                blink_mask = n_mask;
            end
            if (c == valid_at) upd_valid = 1'b1;
            chk("an",  16'(an),  16'((pos < B) ? 8'hFF : cur.an));
            chk("seg", 16'(seg), 16'((pos < B) ? 7'h7F : cur.seg));
            chk("fd_rdy", 16'({frame_done, upd_ready}), (c == FR - 1) ? 16'h0003 : 16'h0000);
            if (c == FR - 1 && upd_valid) acc = 1'b1;
            @(negedge clk);
        end
        if (stop_at >= FR) begin
            m_frame++;
            if (acc) begin
                m_dig     = n_dig;
                m_en      = n_en;
                m_mask    = n_mask;
                upd_valid = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        upd_valid  = 1'b0;
        digits     = 32'h0;
        digit_en   = 8'h00;
        blink_mask = 8'h00;
        repeat (3) @(negedge clk);
        chk_dark("reset");

        // Release: scan begins with the BLANK of digit 0, snapshot empty.
        rst_n   = 1'b1;
        m_dig   = 32'h0;
        m_en    = 8'h00;
        m_mask  = 8'h00;
        m_frame = 0;

        // Frame 0 dark; update offered mid-frame and accepted at cycle 95.
        n_dig  = 32'h76543210;
        n_en   = 8'hFF;
        n_mask = 8'h00;
        run_frame(50, FR);

        // Frame 1 shows 0..7; inputs change at cycle 10 but display must not follow.
        n_dig  = 32'hB9876543;
        n_en   = 8'hFF;
        n_mask = 8'h01;
        run_frame(40, FR);

        // Frames 2-4: digit 0 blinks (off in 2,3, on in 4); digit 7 = 0xB renders blank.
        run_frame(-1, FR);
        run_frame(-1, FR);
        run_frame(-1, FR);

        // Frame 5 offers a partial enable mask, seen in frame 6.
        n_en   = 8'h5A;
        n_mask = 8'h00;
        run_frame(30, FR);
        run_frame(-1, FR);

        // Frame 7 aborted by reset during SHOW of digit 5 (cycle 66).
        run_frame(-1, 5 * W + B + 4);
        #2 rst_n = 1'b0;
        #1 chk_dark("rst_async");
        @(negedge clk);
        chk_dark("rst_hold");
        rst_n   = 1'b1;
        m_dig   = 32'h0;
        m_en    = 8'h00;
        m_mask  = 8'h00;
        m_frame = 0;

        // After reset: dark until an update is accepted, then new digits.
        n_dig  = 32'h13572468;
        n_en   = 8'hFF;
        n_mask = 8'h00;
        run_frame(-1, FR);
        run_frame(20, FR);
        run_frame(-1, FR);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
